// File: rtl/ring_arb_pkg.sv
// Shared types and defaults for the ring round-robin arbiter.
// Contents: arbiter state enumeration, default requester count and hold limit.
package ring_arb_pkg;

  localparam int unsigned N_DEF        = 4;
  localparam int unsigned MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/ring_rr_pick.sv
// Rotate-priority selector: returns the first set req bit at or above the
// one-hot ptr position, wrapping from N-1 back to 0.
// Ports:
//   req  - request vector
//   ptr  - one-hot highest-priority position
//   pick - one-hot selection, all-zero when req is zero
module ring_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] pick
);

  logic [N-1:0] mask;
  logic [N-1:0] hi_req;
  logic         acc;

  // Thermometer mask: bits at or above the ptr position.
  always_comb begin
    mask = '0;
    acc  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      acc     = acc | ptr[i];
      mask[i] = acc;
    end
  end

  // Lowest set bit of the upper region, else wrap to lowest set bit overall.
  always_comb begin
    hi_req = req & mask;
    if (|hi_req) begin
      pick = hi_req & (~hi_req + N'(1));
    end else begin
      pick = req & (~req + N'(1));
    end
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Ring round-robin arbiter with bounded grant hold time.
// A grant is held until the owner pulses done, drops req, or MAX_HOLD cycles
// elapse; every release is followed by a one-cycle GAP and rotates the token.
// Ports:
//   clk       - clock
//   clr       - synchronous active-high reset
//   req       - per-requester request level
//   done      - per-requester release pulse (owner's bit only)
//   gnt       - registered one-hot grant
//   gnt_valid - registered, high when gnt is non-zero
//   ptr       - registered one-hot priority token
//   timeout   - registered one-cycle pulse on MAX_HOLD revocation
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  output logic [N-1:0] ptr,
  output logic         timeout
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;

  logic [N-1:0]  pick;
  logic          own_done;
  logic          own_req;
  logic          expire;

  ring_rr_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick)
  );

  // Owner-qualified release terms; gnt_q is one-hot so masking isolates the owner.
  assign own_done = |(done & gnt_q);
  assign own_req  = |(req & gnt_q);
  assign expire   = (hold_q == HW'(MAX_HOLD));

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      ptr_q     <= N'(1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_OWN;
          gnt_d   = pick;
          hold_d  = HW'(1);
        end
      end
      ST_OWN: begin
        if (own_done || !own_req || expire) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          hold_d    = '0;
          // Token moves to one position above the released owner.
          ptr_d     = {gnt_q[N-2:0], gnt_q[N-1]};
          // Voluntary release wins over simultaneous expiry.
          timeout_d = expire && !own_done && own_req;
        end else if (!expire) begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    endcase

    valid_d = |gnt_d;
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign ptr       = ptr_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Self-checking bench for ring_rr_arbiter: a cycle model pushes expected
// outputs per driven cycle, popped and compared after each rising edge.
module tb_ring_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned MH = 8;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic         valid;
    logic [N-1:0] ptr;
    logic         to;
  } exp_t;

  logic         clk;
  logic         clr;
  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [N-1:0] ptr;
  logic         timeout;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state: 0 idle, 1 own, 2 gap; owner -1 when none.
  int m_state = 0;
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_to    = 0;

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .ptr       (ptr),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic model_step(input logic c, input logic [N-1:0] r, input logic [N-1:0] d);
    logic found;
    logic dn, rq;
    int   idx;
    m_to = 0;
    if (c) begin
      m_state = 0; m_owner = -1; m_ptr = 0; m_hold = 0;
    end else if (m_state == 0) begin
      found = 1'b0;
      for (int o = 0; o < int'(N); o++) begin
        idx = (m_ptr + o) % int'(N);
        if (!found && (((r >> idx) & N'(1)) != '0)) begin
          found = 1'b1; m_owner = idx; m_state = 1; m_hold = 1;
        end
      end
    end else if (m_state == 1) begin
      dn = ((d >> m_owner) & N'(1)) != '0;
      rq = ((r >> m_owner) & N'(1)) != '0;
      if (dn || !rq || m_hold == int'(MH)) begin
        m_to    = (m_hold == int'(MH) && !dn && rq) ? 1 : 0;
        m_ptr   = (m_owner + 1) % int'(N);
        m_owner = -1;
        m_state = 2;
      end else begin
        m_hold++;
      end
    end else begin
      m_state = 0;
    end
  endtask

  // Drive one cycle, push expectation, sample after the edge and compare.
  task automatic cyc(input logic c, input logic [N-1:0] r, input logic [N-1:0] d);
    exp_t e;
    exp_t got;
    clr = c; req = r; done = d;
    model_step(c, r, d);
    e.gnt   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.valid = (m_owner >= 0);
    e.ptr   = N'(1) << m_ptr;
    e.to    = (m_to != 0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got.gnt = gnt; got.valid = gnt_valid; got.ptr = ptr; got.to = timeout;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      chk("gnt",       8'(got.gnt),   8'(e.gnt));
      chk("gnt_valid", 8'(got.valid), 8'(e.valid));
      chk("ptr",       8'(got.ptr),   8'(e.ptr));
      chk("timeout",   8'(got.to),    8'(e.to));
      chk("ptr_onehot", 8'($onehot(got.ptr)), 8'd1);
    end
  endtask

  int           n_hi;
  int           n_to;
  logic [N-1:0] oh;
  logic [N-1:0] rr;
  logic [N-1:0] dd;

  initial begin
    clr = 1'b1; req = '0; done = '0;

    // Reset and first grant from token position 0.
    cyc(1'b1, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b0000, 4'b0000);
    chk("rst_gnt", 8'(gnt), 8'h0);
    chk("rst_ptr", 8'(ptr), 8'h1);
    cyc(1'b0, 4'b0110, 4'b0000);
    chk("first_gnt", 8'(gnt), 8'h2);
    chk("first_ptr", 8'(ptr), 8'h1);
    cyc(1'b0, 4'b0110, 4'b0000);
    chk("hold_ptr", 8'(ptr), 8'h1);
    cyc(1'b0, 4'b0000, 4'b0000);
    chk("drop_ptr", 8'(ptr), 8'h4);
    cyc(1'b0, 4'b0000, 4'b1111);
    cyc(1'b0, 4'b0000, 4'b1111);

    // Full contention with done after 3 hold cycles: strict rotation.
    cyc(1'b1, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      oh = N'(1) << (k % int'(N));
      cyc(1'b0, 4'b1111, 4'b0000);
      chk("rot_gnt", 8'(gnt), 8'(oh));
      cyc(1'b0, 4'b1111, 4'b0000);
      cyc(1'b0, 4'b1111, 4'b0000);
      cyc(1'b0, 4'b1111, oh);
      chk("rot_rel", 8'(gnt), 8'h0);
      cyc(1'b0, 4'b1111, 4'b0000);
      chk("rot_gap", 8'(gnt), 8'h0);
    end

    // Sole requester holding past MAX_HOLD.
    cyc(1'b1, 4'b0000, 4'b0000);
    n_hi = 0; n_to = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 4'b0100, 4'b0000);
      if (gnt_valid) n_hi++;
      if (timeout) n_to++;
    end
    chk("expire_hold_cycles", 8'(n_hi), 8'd8);
    chk("expire_to_pulses", 8'(n_to), 8'd1);
    cyc(1'b0, 4'b0100, 4'b0000);
    chk("regrant", 8'(gnt), 8'h4);

    // Owner done on 8th hold cycle, non-owner done ignored.
    cyc(1'b1, 4'b0000, 4'b0000);
    cyc(1'b0, 4'b0010, 4'b0000);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 4'b0010, (k % 2 == 0) ? 4'b1000 : 4'b0000);
      chk("nonowner_done", 8'(gnt), 8'h2);
    end
    cyc(1'b0, 4'b0010, 4'b0010);
    chk("done_at_max_to", 8'(timeout), 8'h0);
    chk("done_at_max_gnt", 8'(gnt), 8'h0);
    chk("done_at_max_ptr", 8'(ptr), 8'h4);

    // clr mid-grant, then fresh grant to requester 3.
    cyc(1'b0, 4'b0000, 4'b0000);
    cyc(1'b0, 4'b0100, 4'b0000);
    cyc(1'b0, 4'b0100, 4'b0000);
    cyc(1'b1, 4'b0100, 4'b0000);
    chk("clr_gnt", 8'(gnt), 8'h0);
    chk("clr_ptr", 8'(ptr), 8'h1);
    chk("clr_to", 8'(timeout), 8'h0);
    cyc(1'b0, 4'b1000, 4'b0000);
    chk("post_clr_gnt", 8'(gnt), 8'h8);

    // Owner 3 drops req on 4th hold cycle: token wraps to 0.
    cyc(1'b0, 4'b1000, 4'b0000);
    cyc(1'b0, 4'b1000, 4'b0000);
    cyc(1'b0, 4'b1000, 4'b0000);
    cyc(1'b0, 4'b0000, 4'b0000);
    chk("wrap_gnt", 8'(gnt), 8'h0);
    chk("wrap_ptr", 8'(ptr), 8'h1);
    chk("wrap_to", 8'(timeout), 8'h0);

    // Randomised traffic against the model.
    rr = '0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) rr = N'($urandom);
      dd = ($urandom_range(0, 6) == 0) ? N'($urandom) : '0;
      cyc(($urandom_range(0, 60) == 0), rr, dd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ring_rr_arbiter.md
RING_RR_ARBITER -- requirements
Module: ring_rr_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter MAX_HOLD, default 8, maximum cycles one grant may be held (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clr  input  1  reset; synchronous, active-high.
REQ-005 req  input  N  per-requester request level; bit i = requester i.
REQ-006 done  input  N  per-requester release pulse; only the current owner's bit is honoured.
REQ-007 gnt  output  N  registered one-hot grant; all-zero when no owner.
REQ-008 gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-009 ptr  output  N  registered one-hot ring token; marks the highest-priority requester for the next arbitration.
REQ-010 timeout  output  1  registered one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, OWN, GAP.
REQ-012 IDLE: when req is non-zero, the block SHALL select the first set req bit at or after the ptr position, scanning upward with wrap from N-1 to 0, and enter OWN.
REQ-013 Grant latency SHALL be one cycle: req sampled at edge t -> gnt/gnt_valid high after edge t+1.
REQ-014 OWN: gnt SHALL hold the selected one-hot value unchanged while the owner's req stays high and no release occurs.
REQ-015 Hold counter SHALL load 1 on entering OWN, increment each OWN cycle, width clog2(MAX_HOLD+1), and never wrap.
REQ-016 Release SHALL occur on the first of: done[owner]=1; req[owner]=0; hold counter = MAX_HOLD.
REQ-017 On release: gnt=0, gnt_valid=0, state GAP, ptr rotated to one position above the released owner (wrap N-1 -> 0).
REQ-018 GAP SHALL last exactly one cycle, then return to IDLE; next grant earliest two cycles after the release edge.
REQ-019 timeout SHALL pulse for one cycle coincident with entering GAP only when release was due to MAX_HOLD expiry.
REQ-020 Simultaneous done[owner] (or req[owner] low) and expiry: treated as normal release; timeout SHALL stay 0.
REQ-021 done bits of non-owners, and done in IDLE/GAP, SHALL be ignored.
REQ-022 A sole persistent requester SHALL be re-granted after each GAP (no starvation, no lockout).
REQ-023 With all N requesting continuously, grants SHALL rotate 0,1,..,N-1,0 in strict order.
REQ-024 ptr SHALL always be one-hot; it changes only on release.

Reset
REQ-025 While clr is high at a rising edge: state IDLE, gnt=0, gnt_valid=0, timeout=0, hold counter=0, ptr=one-hot bit 0.
REQ-026 clr mid-grant SHALL drop gnt on the following edge with no GAP cycle and no timeout pulse.
REQ-027 First grant after clr deasserts follows REQ-013 from the first edge with clr low.

Structure
REQ-028 A shared package ring_arb_pkg SHALL hold the state enumeration and default constants for N and MAX_HOLD.
REQ-029 Rotate-priority selection SHALL be a purely combinational sub-module ring_rr_pick (inputs req, ptr; output one-hot pick); the FSM, counter and ptr registers live in ring_rr_arbiter.
REQ-030 All outputs SHALL be driven directly from flops.

Verification
REQ-031 clr 2 cycles, then req=0b0110 -> gnt=0b0010 one cycle later; ptr=0b0001 until release.
REQ-032 req=0b1111 held, each owner pulses done after 3 cycles -> gnt sequence 0001,0010,0100,1000,0001 with one-cycle all-zero gap between each.
REQ-033 req=0b0100 held, no done, MAX_HOLD=8 -> gnt high exactly 8 cycles, timeout pulses once, re-grant 0b0100 after one gap cycle.
REQ-034 Owner 1 asserts done on its 8th hold cycle -> release with timeout=0; done[3] pulsed during owner-1 grant has no effect.
REQ-035 Owner 2 granted, clr asserted on 2nd hold cycle -> next edge gnt=0, ptr=0b0001, timeout=0; req=0b1000 afterwards -> gnt=0b1000 one cycle later.
REQ-036 Owner 3 drops req on 4th hold cycle with N=4 -> gnt=0 next edge, ptr wraps to 0b0001, timeout=0.
